// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the divided-clock monitor.
package clkdiv_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  // Expected clk_src cycles in one window of `window` divided-clock rises.
  function automatic int calc_expect_ticks(real clk_src_hz, real clk_div_hz, int window);
    return $rtoi($floor(real'(window) * clk_src_hz / clk_div_hz + 0.5));
  endfunction

endpackage

// File: rtl/clkdiv_monitor_sync_edge.sv
// Brings the divided clock into the clk_src domain and flags its edges.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  // Combinational detect; the consumer registers these together with its measurements.
  assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;
  assign fall = ~sync_reg[SYNC_STAGES-1] & prev_reg;

endmodule

// File: rtl/clkdiv_monitor.sv
// Edge enables, period/window measurement and lock/loss detection for a
// fractionally divided clock sampled in the clk_src domain.
module clkdiv_monitor
  import clkdiv_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int CNT_W        = 16,
  parameter int PER_W        = 8,
  parameter int WINDOW       = 256,
  parameter int EXPECT_TICKS = 8940,
  parameter int TOL          = 4,
  parameter int LOCK_WINDOWS = 2,
  parameter int TIMEOUT      = 128
) (
  input  logic             clk_src,
  input  logic             rst_n,
  input  logic             clk_in,
  output logic             ce_rise,
  output logic             ce_fall,
  output logic [PER_W-1:0] period,
  output logic [CNT_W-1:0] window_ticks,
  output logic             window_valid,
  output logic             locked,
  output logic             lost
);

  localparam int EW = $clog2(WINDOW);
  localparam int GW = $clog2(LOCK_WINDOWS + 1);
  localparam logic [PER_W-1:0]        PCNT_MAX  = '1;
  localparam logic [PER_W-1:0]        PCNT_TO   = PER_W'(TIMEOUT - 1);
  localparam logic [EW-1:0]           ECNT_LAST = EW'(WINDOW - 1);
  localparam logic [GW-1:0]           GOOD_FULL = GW'(LOCK_WINDOWS);
  localparam logic signed [CNT_W:0]   EXP_S     = (CNT_W+1)'(EXPECT_TICKS);
  localparam logic [CNT_W:0]          TOL_U     = (CNT_W+1)'(TOL);

  logic rise, fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
    .clk  (clk_src),
    .rst_n(rst_n),
    .din  (clk_in),
    .rise (rise),
    .fall (fall)
  );

  state_t             state_reg, state_next;
  logic [PER_W-1:0]   pcnt_reg, pcnt_next;
  logic [CNT_W-1:0]   acc_reg, acc_next;
  logic [EW-1:0]      ecnt_reg, ecnt_next;
  logic [GW-1:0]      good_reg, good_next;
  logic [PER_W-1:0]   period_reg, period_next;
  logic [CNT_W-1:0]   window_ticks_reg, window_ticks_next;
  logic               window_valid_reg, window_valid_next;
  logic               locked_reg, locked_next;
  logic               lost_reg, lost_next;
  logic               ce_rise_reg, ce_fall_reg;

  logic [CNT_W:0]         acc_sum;
  logic [CNT_W-1:0]       acc_new;
  logic signed [CNT_W:0]  diff;
  logic [CNT_W:0]         diff_abs;
  logic                   pass;
  logic [GW-1:0]          good_inc;

  assign acc_sum  = {1'b0, acc_reg} + (CNT_W+1)'(pcnt_reg) + (CNT_W+1)'(1);
  assign acc_new  = acc_sum[CNT_W] ? '1 : acc_sum[CNT_W-1:0];
  assign diff     = $signed({1'b0, acc_new}) - EXP_S;
  assign diff_abs = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
  assign pass     = (diff_abs <= TOL_U);
  assign good_inc = (good_reg == GOOD_FULL) ? good_reg : good_reg + GW'(1);

  always_comb begin
    state_next        = state_reg;
    pcnt_next         = (pcnt_reg == PCNT_MAX) ? pcnt_reg : pcnt_reg + PER_W'(1);
    acc_next          = acc_reg;
    ecnt_next         = ecnt_reg;
    good_next         = good_reg;
    period_next       = period_reg;
    window_ticks_next = window_ticks_reg;
    window_valid_next = 1'b0;
    locked_next       = locked_reg;
    lost_next         = lost_reg;

    if (rise) begin
      pcnt_next = '0;
      if (state_reg == IDLE) begin
        // The interval before the start edge is partial, so it is never measured.
        state_next = MEASURE;
        acc_next   = '0;
        ecnt_next  = '0;
        lost_next  = 1'b0;
      end else begin
        period_next = pcnt_reg + PER_W'(1);
        acc_next    = acc_new;
        ecnt_next   = ecnt_reg + EW'(1);
        if (ecnt_reg == ECNT_LAST) begin
          window_ticks_next = acc_new;
          window_valid_next = 1'b1;
          acc_next          = '0;
          if (pass) begin
            good_next = good_inc;
            if (good_inc == GOOD_FULL) locked_next = 1'b1;
          end else begin
            good_next   = '0;
            locked_next = 1'b0;
          end
        end
      end
    end else if (pcnt_reg == PCNT_TO) begin
      lost_next   = 1'b1;
      locked_next = 1'b0;
      good_next   = '0;
      state_next  = IDLE;
      acc_next    = '0;
      ecnt_next   = '0;
    end
  end

  always_ff @(posedge clk_src) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      pcnt_reg         <= '0;
      acc_reg          <= '0;
      ecnt_reg         <= '0;
      good_reg         <= '0;
      period_reg       <= '0;
      window_ticks_reg <= '0;
      window_valid_reg <= 1'b0;
      locked_reg       <= 1'b0;
      lost_reg         <= 1'b0;
      ce_rise_reg      <= 1'b0;
      ce_fall_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      pcnt_reg         <= pcnt_next;
      acc_reg          <= acc_next;
      ecnt_reg         <= ecnt_next;
      good_reg         <= good_next;
      period_reg       <= period_next;
      window_ticks_reg <= window_ticks_next;
      window_valid_reg <= window_valid_next;
      locked_reg       <= locked_next;
      lost_reg         <= lost_next;
      ce_rise_reg      <= rise;
      ce_fall_reg      <= fall;
    end
  end

  assign ce_rise      = ce_rise_reg;
  assign ce_fall      = ce_fall_reg;
  assign period       = period_reg;
  assign window_ticks = window_ticks_reg;
  assign window_valid = window_valid_reg;
  assign locked       = locked_reg;
  assign lost         = lost_reg;

endmodule
